// File: rtl/lynxTypes.sv
// lynxTypes: shared user-wrapper types.
//   req_t     - descriptor carried on the bypass write-request channel
//   PID_BITS  - width of the completion PID
//   N_WR_REQ  - default number of write requesters sharing the bypass port
package lynxTypes;

    localparam int PID_BITS = 6;
    localparam int N_WR_REQ = 4;

    typedef struct packed {
        logic [47:0]         vaddr;
        logic [9:0]          len;
        logic [PID_BITS-1:0] pid;
    } req_t;

endpackage

// File: rtl/bpss_wr_arbiter_if.sv
// bpss_wr_arbiter_if: descriptor-bypass write channel.
//   bpss_wr_req_*  - write request (valid/ready/data), arbiter -> bypass
//   bpss_wr_done_* - completion (valid/ready/pid), bypass -> arbiter
// Modports: master = arbiter side, slave = bypass side.
interface bpss_wr_arbiter_if;
    import lynxTypes::*;

    logic                bpss_wr_req_valid;
    logic                bpss_wr_req_ready;
    req_t                bpss_wr_req_data;
    logic                bpss_wr_done_valid;
    logic                bpss_wr_done_ready;
    logic [PID_BITS-1:0] bpss_wr_done_data;

    modport master (
        output bpss_wr_req_valid, bpss_wr_req_data, bpss_wr_done_ready,
        input  bpss_wr_req_ready, bpss_wr_done_valid, bpss_wr_done_data
    );

    modport slave (
        input  bpss_wr_req_valid, bpss_wr_req_data, bpss_wr_done_ready,
        output bpss_wr_req_ready, bpss_wr_done_valid, bpss_wr_done_data
    );

endinterface

// File: rtl/bpss_tag_fifo.sv
// bpss_tag_fifo: synchronous FIFO holding the owner tag of each in-flight write.
//   aclk/aresetn   - clock, async active-low reset (empties the FIFO)
//   wr_en/wr_data  - push; accepted when not full, or when full with a pop
//   rd_en/rd_data  - pop; rd_data shows the head combinationally
//   full/empty     - occupancy flags
module bpss_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_wr, do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bpss_wr_arbiter.sv
// bpss_wr_arbiter: round-robin sharing of the bypass write-request channel.
//   aclk/aresetn          - clock, async active-low reset
//   ctrl_en               - gate for new grants; in-flight traffic drains
//   req_valid/ready/data  - per-requester descriptor handshake
//   bpss                  - bypass request + completion channel (master side)
//   done_valid/done_pid   - one-cycle completion pulse to the owning requester
//   outstanding           - per-requester in-flight count
//   busy                  - tag FIFO non-empty or a request waiting in SEND
module bpss_wr_arbiter
    import lynxTypes::*;
#(
    parameter int N_REQ     = N_WR_REQ,
    parameter int MAX_OUT   = 8,
    parameter int TAG_DEPTH = 16
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   ctrl_en,
    input  logic [N_REQ-1:0]                       req_valid,
    output logic [N_REQ-1:0]                       req_ready,
    input  req_t [N_REQ-1:0]                       req_data,
    bpss_wr_arbiter_if.master                      bpss,
    output logic [N_REQ-1:0]                       done_valid,
    output logic [PID_BITS-1:0]                    done_pid,
    output logic [N_REQ-1:0][$clog2(MAX_OUT):0]    outstanding,
    output logic                                   busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_OUT) + 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    last_grant, winner, pop_tag;
    logic [IW:0]      pick;
    logic [N_REQ-1:0] elig, inc, dec;
    logic             grant, pop, fifo_full, fifo_empty;
    req_t             out_data;

    // First eligible requester after `last`, wrapping. Returns {found, index}.
    // Walking the distance downwards lets the nearest candidate overwrite.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] e,
                                            input logic [IW-1:0]    last);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (e[idx]) res = {1'b1, idx[IW-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            elig[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUT)) && !fifo_full && ctrl_en;
    end

    assign pick   = rr_pick(elig, last_grant);
    assign winner = pick[IW-1:0];

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        grant     = 1'b0;
        case (state)
            IDLE: if (pick[IW]) begin
                grant             = 1'b1;
                req_ready[winner] = 1'b1;
                state_nxt         = SEND;
            end
            SEND: if (bpss.bpss_wr_req_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            out_data   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_grant <= winner;
                out_data   <= req_data[winner];
            end
        end
    end

    assign bpss.bpss_wr_req_valid  = (state == SEND);
    assign bpss.bpss_wr_req_data   = out_data;
    // Completions without an owner stall rather than drop.
    assign bpss.bpss_wr_done_ready = !fifo_empty;
    assign pop                     = bpss.bpss_wr_done_valid && !fifo_empty;
    assign busy                    = !fifo_empty || (state == SEND);

    bpss_tag_fifo #(.W(IW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (grant),
        .wr_data (winner),
        .rd_en   (pop),
        .rd_data (pop_tag),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign inc = grant ? (N_REQ'(1) << winner)  : '0;
    assign dec = pop   ? (N_REQ'(1) << pop_tag) : '0;

    // Grant and completion on the same requester cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
            done_valid  <= '0;
            done_pid    <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (inc[i] && !dec[i])      outstanding[i] <= outstanding[i] + CW'(1);
                else if (dec[i] && !inc[i]) outstanding[i] <= outstanding[i] - CW'(1);
            end
            done_valid <= dec;
            if (pop) done_pid <= bpss.bpss_wr_done_data;
        end
    end

endmodule

// File: tb/tb_bpss_wr_arbiter.sv
module tb_bpss_wr_arbiter;
    import lynxTypes::*;

    localparam int N  = 4;
    localparam int MO = 8;
    localparam int TD = 16;
    localparam int CW = $clog2(MO) + 1;

    logic                       aclk = 1'b0;
    logic                       aresetn = 1'b0;
    logic                       ctrl_en = 1'b0;
    logic [N-1:0]               req_valid = '0;
    logic [N-1:0]               req_ready;
    req_t [N-1:0]               req_data = '0;
    logic [N-1:0]               done_valid;
    logic [PID_BITS-1:0]        done_pid;
    logic [N-1:0][CW-1:0]       outstanding;
    logic                       busy;

    bpss_wr_arbiter_if bif();

    bpss_wr_arbiter #(.N_REQ(N), .MAX_OUT(MO), .TAG_DEPTH(TD)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .ctrl_en     (ctrl_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .bpss        (bif),
        .done_valid  (done_valid),
        .done_pid    (done_pid),
        .outstanding (outstanding),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending request flag, round-robin pointer,
    // ownership queue in issue order, per-requester credit counts.
    bit                  m_send;
    req_t                m_data;
    int                  m_lg;
    int                  m_tq[$];
    int                  m_out[N];
    logic [N-1:0]        m_dv;
    logic [PID_BITS-1:0] m_pid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_send = 1'b0;
        m_data = '0;
        m_lg   = N - 1;
        m_tq.delete();
        foreach (m_out[i]) m_out[i] = 0;
        m_dv   = '0;
        m_pid  = '0;
    endtask

    // One clock: drive at negedge, check just after, then advance the model
    // to what the next posedge should produce.
    task automatic step(input logic [N-1:0] rv, input bit en, input bit brdy,
                        input bit dval, input logic [PID_BITS-1:0] dpid);
        int           w;
        int           t;
        logic [N-1:0] exp_rdy;
        @(negedge aclk);
        req_valid                = rv;
        ctrl_en                  = en;
        bif.bpss_wr_req_ready    = brdy;
        bif.bpss_wr_done_valid   = dval;
        bif.bpss_wr_done_data    = dpid;
        for (int i = 0; i < N; i++) req_data[i] = req_t'({$urandom(), $urandom()});
        #1;
        w = -1;
        if (!m_send && aresetn) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_lg + k) % N;
                if (w < 0 && rv[c] && m_out[c] < MO && m_tq.size() < TD && en) w = c;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("wr_req_valid", bif.bpss_wr_req_valid, m_send);
        chk("wr_req_data", bif.bpss_wr_req_data, m_data);
        chk("wr_done_ready", bif.bpss_wr_done_ready, m_tq.size() > 0);
        chk("done_valid", done_valid, m_dv);
        chk("done_pid", done_pid, m_pid);
        for (int i = 0; i < N; i++) chk($sformatf("outstanding[%0d]", i), outstanding[i], m_out[i]);
        chk("busy", busy, m_send || m_tq.size() > 0);
        if (!aresetn) return;
        m_dv = '0;
        if (dval && m_tq.size() > 0) begin
            t = m_tq.pop_front();
            m_out[t]--;
            m_dv[t] = 1'b1;
            m_pid   = dpid;
        end
        if (w >= 0) begin
            m_tq.push_back(w);
            m_out[w]++;
            m_lg   = w;
            m_send = 1'b1;
            m_data = req_data[w];
        end else if (m_send && brdy) begin
            m_send = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b1, 1'b1, PID_BITS'($urandom()));
    endtask

    initial begin
        bif.bpss_wr_req_ready  = 1'b0;
        bif.bpss_wr_done_valid = 1'b0;
        bif.bpss_wr_done_data  = '0;
        model_reset();

        // Reset values.
        step('0, 1'b0, 1'b0, 1'b0, '0);
        step('0, 1'b0, 1'b0, 1'b0, '0);
        aresetn = 1'b1;

        // Single requester: three grants, then three completions.
        for (int i = 0; i < 6; i++) step(4'b0001, 1'b1, 1'b1, 1'b0, '0);
        chk("single_out0", outstanding[0], 3);
        step('0, 1'b1, 1'b1, 1'b1, 6'd5);
        step('0, 1'b1, 1'b1, 1'b1, 6'd6);
        step('0, 1'b1, 1'b1, 1'b1, 6'd7);
        step('0, 1'b1, 1'b1, 1'b0, '0);
        chk("single_last_pid", done_pid, 7);
        chk("single_out0_zero", outstanding[0], 0);

        // All requesters valid: strict rotation.
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < N; i++) chk($sformatf("rotation_out[%0d]", i), outstanding[i], 2);
        drain(10);

        // Credit limit on requester 2.
        for (int i = 0; i < 20; i++) step(4'b0100, 1'b1, 1'b1, 1'b0, '0);
        chk("credit_out2", outstanding[2], MO);
        chk("credit_stall", req_ready, 0);
        step(4'b0100, 1'b1, 1'b1, 1'b1, 6'd9);
        step(4'b0100, 1'b1, 1'b1, 1'b0, '0);
        step('0, 1'b1, 1'b1, 1'b0, '0);
        drain(10);

        // Backpressure with ctrl_en dropped mid-SEND.
        step(4'b0001, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(4'b1111, i < 5, 1'b0, 1'b0, '0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, '0);
        drain(4);

        // Ordering: grants 1 then 3, done coincides with a new grant to 1.
        step(4'b0010, 1'b1, 1'b1, 1'b0, '0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, '0);
        step(4'b1000, 1'b1, 1'b1, 1'b0, '0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, '0);
        step(4'b0010, 1'b1, 1'b1, 1'b1, 6'd21);
        step(4'b0000, 1'b1, 1'b1, 1'b1, 6'd22);
        chk("same_cycle_dv1", done_valid, 4'b0010);
        step(4'b0000, 1'b1, 1'b1, 1'b1, 6'd23);
        chk("ordered_dv3", done_valid, 4'b1000);
        step(4'b0000, 1'b1, 1'b1, 1'b1, 6'd24);
        step(4'b0000, 1'b1, 1'b1, 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(N'($urandom()), ($urandom() % 8) != 0, ($urandom() % 4) != 0,
                 ($urandom() % 10) < 3, PID_BITS'($urandom()));
        drain(TD + 4);

        // Reset while in SEND with several requests in flight.
        for (int i = 0; i < 11; i++) step(4'b0001, 1'b1, 1'b1, 1'b0, '0);
        @(negedge aclk);
        req_valid             = '0;
        bif.bpss_wr_req_ready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_wr_req_valid", bif.bpss_wr_req_valid, 0);
        chk("rst_wr_req_data", bif.bpss_wr_req_data, 0);
        chk("rst_done_ready", bif.bpss_wr_done_ready, 0);
        chk("rst_out0", outstanding[0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        model_reset();
        step('0, 1'b1, 1'b0, 1'b0, '0);
        aresetn = 1'b1;
        step(4'b1111, 1'b1, 1'b1, 1'b0, '0);
        chk("post_rst_winner0", req_ready, 4'b0001);
        step(4'b0000, 1'b1, 1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpss_wr_arbiter.md
# bpss_wr_arbiter

Round-robin arbiter that shares the single descriptor-bypass write-request channel (`bpss_wr_req`) among `N_REQ` user-logic requesters. It sits inside the user wrapper, between user-logic engines and the bypass ports.

- Each requester gets a per-requester outstanding-request credit limit.
- A tag FIFO records which requester owns each in-flight request.
- Completions on `bpss_wr_done` return in issue order. Each completion is routed back to its owning requester as a one-cycle pulse.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_OUT`, 8: max outstanding writes per requester (power of 2).
- `TAG_DEPTH`, 16: tag FIFO depth (power of 2, ≥ `MAX_OUT`).

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: reset, asynchronous and active-low.
- `ctrl_en` in 1: when 0, no new grants are made; in-flight traffic drains.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept, one-hot or zero.
- `req_data` in `N_REQ` x `req_t`: per-requester descriptor.
- `bpss_wr_req_valid` out 1, `bpss_wr_req_ready` in 1, `bpss_wr_req_data` out `req_t`: request to the bypass channel.
- `bpss_wr_done_valid` in 1, `bpss_wr_done_ready` out 1, `bpss_wr_done_data` in `PID_BITS`: completion from the bypass channel.
- `done_valid` out `N_REQ`: one-cycle completion pulse to the owning requester.
- `done_pid` out `PID_BITS`: PID of the completion, valid with `done_valid`.
- `outstanding` out `N_REQ` x `$clog2(MAX_OUT)+1`: per-requester in-flight count.
- `busy` out 1: high while the tag FIFO is non-empty or the FSM is in `SEND`.

## Operation
State machine with states `IDLE` and `SEND`. Reset state is `IDLE`.
- Eligible requester `i`: `req_valid[i]`, `outstanding[i] < MAX_OUT`, tag FIFO not full, and `ctrl_en`.
- `IDLE`: search for an eligible requester starting at `(last_grant+1) mod N_REQ`; the first eligible one wins.
  - Assert `req_ready[winner]` combinationally in that cycle.
  - Register `req_data[winner]` into the output register.
  - Push `winner` into the tag FIFO and increment `outstanding[winner]`.
  - Set `last_grant = winner` and go to `SEND`.
  - With no eligible requester, stay in `IDLE`.
- `SEND`: `bpss_wr_req_valid=1` and the output data is held stable. On `bpss_wr_req_ready`, go to `IDLE`.
  - `ctrl_en` falling during `SEND` does not retract valid.
- Completion path:
  - `bpss_wr_done_ready` is 1 exactly when the tag FIFO is non-empty. With the FIFO empty, a done stalls; it is never dropped.
  - On a done handshake: pop tag `t`, decrement `outstanding[t]`, and register `done_valid[t]=1` and `done_pid=bpss_wr_done_data`.
- Push and pop in the same cycle on the same requester: the count is unchanged. On different requesters, each count updates independently.
- The tag FIFO accepts simultaneous push and pop when full (pop first) or empty (push is visible next cycle).
- Counter arithmetic is unsigned and never wraps; the eligibility check guarantees `outstanding ≤ MAX_OUT`.

## Timing
- Reset values:
  - FSM: `IDLE`.
  - `last_grant`: `N_REQ-1`, so requester 0 has first priority.
  - `req_ready`: 0.
  - `bpss_wr_req_valid`: 0.
  - `bpss_wr_req_data`: 0.
  - `bpss_wr_done_ready`: 0.
  - `done_valid`: 0.
  - `done_pid`: 0.
  - `outstanding`: all 0.
  - `busy`: 0.
  - Tag FIFO: empty.
- Reset mid-operation: all state clears immediately, including the tag FIFO and counters. In-flight requests are forgotten.
- Latency:
  - Accept in cycle k gives `bpss_wr_req_valid` in cycle k+1.
  - Peak throughput is 1 request per 2 cycles.
  - A done handshake in cycle k gives the `done_valid` pulse in cycle k+1.
- `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- `bpss_wr_req_valid` never deasserts without a handshake.

## Structure
- Shared package (`lynxTypes`): `req_t` and `PID_BITS` (existing). Add `localparam N_WR_REQ` as the default value of `N_REQ`.
- One sub-module, `bpss_tag_fifo`: a synchronous FIFO of width `$clog2(N_REQ)` and depth `TAG_DEPTH`, with `full`/`empty` flags and an async active-low reset.
- The round-robin search is a combinational function inside the top module.

## Test plan
- Single requester, `N_REQ=4`: `req0` issues 3 requests, bypass ready held at 1. Expect 3 `bpss_wr_req` handshakes 2 cycles apart and `outstanding[0]=3`. Return 3 dones with PIDs 5, 6, 7; expect 3 `done_valid[0]` pulses carrying those PIDs and `outstanding[0]=0`.
- All 4 requesters valid continuously: the grant order is 0,1,2,3,0,1,… and each requester's `outstanding` increases by exactly 1 per round.
- Credit limit, `MAX_OUT=8`: `req2` issues 9 requests with no dones. Expect 8 accepted and the 9th stalled (`req_ready[2]=0`). One done frees credit, and the 9th is accepted within 2 cycles.
- Backpressure: hold `bpss_wr_req_ready=0` for 10 cycles during `SEND`. Valid and data must stay stable, `req_ready` must stay all 0, and `ctrl_en` toggled to 0 must not drop valid.
- Completion ordering and a same-cycle event: grants go 1 then 3. A done arrives in the same cycle as a new grant to 1. Expect a `done_valid[1]` pulse, `outstanding[1]` unchanged, and the next done routed to 3. A done with an empty FIFO sees `bpss_wr_done_ready=0`.
- Reset mid-`SEND` with 5 requests in flight: all outputs return to their reset values asynchronously, `busy=0`, and requester 0 wins the first grant after reset.
